cpu_bus_sequencer: RTL and testbench

- Sequences every CPU memory access into 4-T-state M-cycles and drives the external memory bus.
- Input is a bus_opcode_t (IDLE/IF/WRITE/READ) from the decoder. It latches read data for the register file and loads the opcode register on instruction fetch.
- Arbitrates the CPU against OAM DMA: while DMA runs, the CPU may access HRAM only.
- Sits between the control unit / decode FSM and the system bus; one clk equals one T-state.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cpu_bus_sequencer_mcycle_timer.sv | 37 +++
 rtl/cpu_bus_sequencer.sv | 91 +++++++++
 tb/tb_cpu_bus_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU bus types and constants.
// Bus opcodes, T-state encoding and the HRAM window used during DMA.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_IF    = 2'd1,
    OP_WRITE = 2'd2,
    OP_READ  = 2'd3
  } bus_opcode_t;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2,
    T4 = 2'd3
  } t_state_t;

  localparam logic [15:0] HRAM_LO       = 16'hFF80;
  localparam logic [15:0] HRAM_HI       = 16'hFFFE;
  localparam logic [7:0]  BLOCKED_RDATA = 8'hFF;

  function automatic logic dma_blocks(
    input logic        dma,
    input bus_opcode_t op,
    input logic [15:0] a
  );
    return dma && (op != OP_IDLE) &&
           ((a < HRAM_LO) || (a > HRAM_HI));
  endfunction

endpackage

// File: rtl/cpu_bus_sequencer_mcycle_timer.sv
// Free-running T-state counter, one clk per T-state.
// Also used by interrupt/halt logic to find M-cycle edges.
module mcycle_timer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] t_phase,
  output logic       mcycle_done
);

  t_state_t state, state_nx;

  // State register: synchronous reset back to T1
  always_ff @(posedge clk) begin
    if (rst) state <= T1;
    else     state <= state_nx;
  end

  // Next state: T1 -> T2 -> T3 -> T4 -> T1, never stalls
  always_comb begin
    state_nx = T1;
    case (state)
      T1:      state_nx = T2;
      T2:      state_nx = T3;
      T3:      state_nx = T4;
      default: state_nx = T1;
    endcase
  end

  // Outputs: phase number and end-of-M-cycle marker
  always_comb begin
    t_phase     = state;
    mcycle_done = (state == T4);
  end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// CPU memory bus sequencer: turns decoder requests into M-cycles.
// Requests are sampled on the T4->T1 edge; DMA restricts CPU to HRAM.
module cpu_bus_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  bus_opcode_t bus_op,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wdata_in,
  input  logic [7:0]  mem_rdata,
  input  logic        dma_active,
  output logic [1:0]  t_phase,
  output logic        mcycle_done,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  rdata_q,
  output logic        rdata_valid,
  output logic        ir_load,
  output logic        blocked
);

  bus_opcode_t op_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        blk_q;
  logic        blk_in;
  logic        rd_in;
  logic        rd_q;

  mcycle_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .t_phase     (t_phase),
    .mcycle_done (mcycle_done)
  );

  // Block decision and read-type decode for the incoming request
  always_comb begin
    blk_in = dma_blocks(dma_active, bus_op, addr_in);
    rd_in  = (bus_op == OP_READ) || (bus_op == OP_IF);
    rd_q   = (op_q == OP_READ) || (op_q == OP_IF);
  end

  // Request latch and registered strobes, stepped by T-state
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      blk_q   <= 1'b0;
      rdata_q <= '0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
    end else begin
      case (t_phase)
        2'd3: begin
          op_q    <= bus_op;
          wdata_q <= wdata_in;
          blk_q   <= blk_in;
          if (bus_op != OP_IDLE)
            addr_q <= addr_in;
          mem_rd  <= rd_in && !blk_in;
          mem_wr  <= 1'b0;
        end
        2'd0: begin
          mem_wr <= (op_q == OP_WRITE) && !blk_q;
        end
        2'd2: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          if (rd_q)
            rdata_q <= blk_q ? BLOCKED_RDATA : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Bus-facing views and T4 pulses
  always_comb begin
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    blocked     = blk_q;
    rdata_valid = mcycle_done && (op_q == OP_READ);
    ir_load     = mcycle_done && (op_q == OP_IF);
  end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Bench for cpu_bus_sequencer: vector table plus reset corner case.
// Read data expectations travel through a scoreboard queue.
module tb_cpu_bus_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  bus_opcode_t bus_op;
  logic [15:0] addr_in;
  logic [7:0]  wdata_in;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic [1:0]  t_phase;
  logic        mcycle_done;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  rdata_q;
  logic        rdata_valid;
  logic        ir_load;
  logic        blocked;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  cpu_bus_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .bus_op      (bus_op),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .mem_rdata   (mem_rdata),
    .dma_active  (dma_active),
    .t_phase     (t_phase),
    .mcycle_done (mcycle_done),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .rdata_q     (rdata_q),
    .rdata_valid (rdata_valid),
    .ir_load     (ir_load),
    .blocked     (blocked)
  );

  typedef struct {
    bus_opcode_t op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        dma;
    logic        e_rd;
    logic        e_wr;
    logic        e_blk;
    logic        e_valid;
    logic        e_ir;
    logic [15:0] e_addr;
    logic [7:0]  e_rdq;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(
    input bus_opcode_t op, input logic [15:0] a,
    input logic [7:0] wd, input logic [7:0] rd,
    input logic dma, input logic erd, input logic ewr,
    input logic eblk, input logic ev, input logic eir,
    input logic [15:0] ea, input logic [7:0] eq
  );
    vec_t v;
    v.op = op; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.dma = dma; v.e_rd = erd; v.e_wr = ewr; v.e_blk = eblk;
    v.e_valid = ev; v.e_ir = eir; v.e_addr = ea; v.e_rdq = eq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_t4;
    bit ok;
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (t_phase == 2'd3) ok = 1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_t4 actual=timeout required=T4");
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic [7:0] exp_q;
    v = vecs[i];
    bus_op = v.op;
    addr_in = v.addr;
    wdata_in = v.wdata;
    mem_rdata = v.rdata;
    dma_active = v.dma;
    sb_q.push_back(v.e_rdq);
    tick();
    chk($sformatf("v%0d t1_phase", i), 16'(t_phase), 16'd0);
    chk($sformatf("v%0d t1_rd", i), 16'(mem_rd), 16'(v.e_rd));
    chk($sformatf("v%0d t1_wr", i), 16'(mem_wr), 16'd0);
    chk($sformatf("v%0d t1_addr", i), mem_addr, v.e_addr);
    dma_active = ~v.dma;
    addr_in = ~v.addr;
    wdata_in = ~v.wdata;
    bus_op = OP_READ;
    tick();
    chk($sformatf("v%0d t2_rd", i), 16'(mem_rd), 16'(v.e_rd));
    chk($sformatf("v%0d t2_wr", i), 16'(mem_wr), 16'(v.e_wr));
    chk($sformatf("v%0d t2_blk", i), 16'(blocked), 16'(v.e_blk));
    chk($sformatf("v%0d t2_done", i), 16'(mcycle_done), 16'd0);
    if (v.op == OP_WRITE)
      chk($sformatf("v%0d t2_wdata", i), 16'(mem_wdata), 16'(v.wdata));
    tick();
    chk($sformatf("v%0d t3_rd", i), 16'(mem_rd), 16'(v.e_rd));
    chk($sformatf("v%0d t3_wr", i), 16'(mem_wr), 16'(v.e_wr));
    tick();
    chk($sformatf("v%0d t4_phase", i), 16'(t_phase), 16'd3);
    chk($sformatf("v%0d t4_done", i), 16'(mcycle_done), 16'd1);
    chk($sformatf("v%0d t4_rd", i), 16'(mem_rd), 16'd0);
    chk($sformatf("v%0d t4_wr", i), 16'(mem_wr), 16'd0);
    chk($sformatf("v%0d t4_valid", i), 16'(rdata_valid), 16'(v.e_valid));
    chk($sformatf("v%0d t4_ir", i), 16'(ir_load), 16'(v.e_ir));
    chk($sformatf("v%0d t4_addr", i), mem_addr, v.e_addr);
    chk($sformatf("v%0d t4_blk", i), 16'(blocked), 16'(v.e_blk));
    if (v.op == OP_WRITE)
      chk($sformatf("v%0d t4_wdata", i), 16'(mem_wdata), 16'(v.wdata));
    if (sb_q.size() == 0) begin
      chk($sformatf("v%0d sb_empty", i), 16'd1, 16'd0);
    end else begin
      exp_q = sb_q.pop_front();
      chk($sformatf("v%0d rdata_q", i), 16'(rdata_q), 16'(exp_q));
    end
  endtask

  initial begin
    vecs[0]  = mk(OP_READ,  16'hC000, 8'h00, 8'h5A, 0, 1,0,0,1,0, 16'hC000, 8'h5A);
    vecs[1]  = mk(OP_WRITE, 16'hFF40, 8'h3C, 8'hEE, 0, 0,1,0,0,0, 16'hFF40, 8'h5A);
    vecs[2]  = mk(OP_IF,    16'h0100, 8'h00, 8'hC3, 0, 1,0,0,0,1, 16'h0100, 8'hC3);
    vecs[3]  = mk(OP_READ,  16'hC001, 8'h00, 8'h77, 0, 1,0,0,1,0, 16'hC001, 8'h77);
    vecs[4]  = mk(OP_READ,  16'hC000, 8'h00, 8'h12, 1, 0,0,1,1,0, 16'hC000, 8'hFF);
    vecs[5]  = mk(OP_READ,  16'hFF80, 8'h00, 8'h34, 1, 1,0,0,1,0, 16'hFF80, 8'h34);
    vecs[6]  = mk(OP_WRITE, 16'hFF7F, 8'h11, 8'h00, 1, 0,0,1,0,0, 16'hFF7F, 8'h34);
    vecs[7]  = mk(OP_WRITE, 16'hFFFE, 8'h22, 8'h00, 1, 0,1,0,0,0, 16'hFFFE, 8'h34);
    vecs[8]  = mk(OP_IDLE,  16'h1234, 8'h99, 8'h88, 1, 0,0,0,0,0, 16'hFFFE, 8'h34);
    vecs[9]  = mk(OP_READ,  16'hFFFF, 8'h00, 8'h56, 1, 0,0,1,1,0, 16'hFFFF, 8'hFF);
    vecs[10] = mk(OP_WRITE, 16'hFF7F, 8'h44, 8'h00, 0, 0,1,0,0,0, 16'hFF7F, 8'hFF);

    rst = 1'b1;
    bus_op = OP_IDLE;
    addr_in = '0;
    wdata_in = '0;
    mem_rdata = '0;
    dma_active = 1'b0;
    repeat (3) tick();
    chk("rst_phase", 16'(t_phase), 16'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_rdq", 16'(rdata_q), 16'h00);
    chk("rst_wdata", 16'(mem_wdata), 16'h00);
    chk("rst_rd", 16'(mem_rd), 16'd0);
    chk("rst_wr", 16'(mem_wr), 16'd0);
    chk("rst_pulses", {14'd0, rdata_valid, ir_load}, 16'd0);
    rst = 1'b0;
    wait_t4();

    for (int i = 0; i < 11; i++) run_vec(i);

    bus_op = OP_WRITE;
    addr_in = 16'hC010;
    wdata_in = 8'hAA;
    dma_active = 1'b0;
    tick();
    chk("rw_t1_phase", 16'(t_phase), 16'd0);
    tick();
    chk("rw_t2_wr", 16'(mem_wr), 16'd1);
    rst = 1'b1;
    bus_op = OP_READ;
    addr_in = 16'hC002;
    mem_rdata = 8'h9A;
    tick();
    chk("rw_abort_wr", 16'(mem_wr), 16'd0);
    chk("rw_abort_phase", 16'(t_phase), 16'd0);
    chk("rw_abort_rd", 16'(mem_rd), 16'd0);
    rst = 1'b0;
    wait_t4();
    chk("rw_idle_valid", 16'(rdata_valid), 16'd0);
    chk("rw_idle_rdq", 16'(rdata_q), 16'h00);
    tick();
    chk("rw_fresh_rd", 16'(mem_rd), 16'd1);
    chk("rw_fresh_addr", mem_addr, 16'hC002);
    repeat (3) tick();
    chk("rw_fresh_rdq", 16'(rdata_q), 16'h9A);
    chk("rw_fresh_valid", 16'(rdata_valid), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
